weight_fifo_drain_ctrl: RTL and testbench

- Parametrised successor to the weight-FIFO output controller. It drains FIFO_WIDTH weight-FIFO lanes into the PE array write path.
- Adds a programmable burst length, a repeat count, optional per-lane diagonal skew for systolic loading, downstream stall, and abort.
- Sits between the layer sequencer (start/config) and the weight FIFO bank plus the PE weight-write enables.

---
 rtl/weight_fifo_pkg.sv | 23 ++
 rtl/weight_fifo_drain_ctrl_lane_skew.sv | 34 +++
 rtl/weight_fifo_drain_ctrl.sv | 163 ++++++++++++++++
 tb/tb_weight_fifo_drain_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_fifo_pkg.sv
// Shared types and helpers for the weight-FIFO drain controller.
package weight_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    TAIL  = 2'd2
  } state_e;

  // Burst-length field must hold FIFO_DEPTH itself, hence the extra bit.
  function automatic int unsigned len_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned clamp_len(input int unsigned cfg, input int unsigned depth);
    return (cfg > depth) ? depth : cfg;
  endfunction

  function automatic int unsigned clamp_rep(input int unsigned cfg);
    return (cfg == 0) ? 1 : cfg;
  endfunction

endpackage

// File: rtl/weight_fifo_drain_ctrl_lane_skew.sv
// Per-lane activity register: diagonal shift (skew) or broadcast of lane 0.
module lane_skew_shreg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             hold,
  input  logic             clr,
  input  logic             skew,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_nxt;

  always_comb begin
    q_nxt    = '0;
    q_nxt[0] = din;
    for (int i = 1; i < WIDTH; i++) begin
      q_nxt[i] = skew ? q[i-1] : din;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (!hold) begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/weight_fifo_drain_ctrl.sv
// Drains FIFO_WIDTH weight-FIFO lanes into the PE array with burst length,
// repeat count, optional diagonal skew, downstream stall and abort.
module weight_fifo_drain_ctrl
  import weight_fifo_pkg::*;
#(
  parameter  int unsigned FIFO_WIDTH = 16,
  parameter  int unsigned FIFO_DEPTH = 16,
  parameter  int unsigned REP_WIDTH  = 8,
  localparam int unsigned LEN_WIDTH  = len_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [REP_WIDTH-1:0]  cfg_repeat,
  input  logic                  cfg_skew,
  input  logic                  stall,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [FIFO_WIDTH-1:0] fifo_en,
  output logic [FIFO_WIDTH-1:0] w_wen
);

  localparam int unsigned TAIL_W    = (FIFO_WIDTH > 1) ? $clog2(FIFO_WIDTH) : 1;
  localparam int unsigned TAIL_LAST = (FIFO_WIDTH > 1) ? FIFO_WIDTH - 2 : 0;

  state_e                state;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [REP_WIDTH-1:0]  rep_q;
  logic                  skew_q;
  logic [LEN_WIDTH-1:0]  word_cnt;
  logic [REP_WIDTH-1:0]  rep_cnt;
  logic [TAIL_W-1:0]     tail_cnt;
  logic [FIFO_WIDTH-1:0] lane_act;

  logic word_wrap;
  logic last_word;
  logic tail_last;
  logic use_tail;
  logic sr_din;
  logic sr_hold;
  logic sr_clr;
  logic sr_skew;
  logic done_c;

  assign word_wrap = (word_cnt == len_q - LEN_WIDTH'(1));
  assign last_word = word_wrap && (rep_cnt == rep_q - REP_WIDTH'(1));
  assign tail_last = (tail_cnt == TAIL_W'(TAIL_LAST));
  assign use_tail  = skew_q && (FIFO_WIDTH > 1);
  // Mode for the load at acceptance must come from the incoming config.
  assign sr_skew   = (state == IDLE) ? cfg_skew : skew_q;

  // Lane-0 feed, stall hold, abort clear and completion strobe.
  always_comb begin
    sr_din  = 1'b0;
    sr_hold = 1'b0;
    sr_clr  = 1'b0;
    done_c  = 1'b0;
    unique case (state)
      IDLE: begin
        sr_din = start && !abort && (cfg_len != '0);
      end
      DRAIN: begin
        if (abort) begin
          sr_clr = 1'b1;
        end else if (stall) begin
          sr_hold = 1'b1;
        end else begin
          sr_din = !last_word;
          done_c = last_word && !use_tail;
        end
      end
      TAIL: begin
        if (abort) begin
          sr_clr = 1'b1;
        end else if (stall) begin
          sr_hold = 1'b1;
        end else begin
          done_c = tail_last;
        end
      end
      default: sr_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      len_q    <= '0;
      rep_q    <= '0;
      skew_q   <= 1'b0;
      word_cnt <= '0;
      rep_cnt  <= '0;
      tail_cnt <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            if (cfg_len == '0) begin
              cfg_err <= 1'b1;
            end else begin
              len_q    <= LEN_WIDTH'(clamp_len(32'(cfg_len), FIFO_DEPTH));
              rep_q    <= REP_WIDTH'(clamp_rep(32'(cfg_repeat)));
              skew_q   <= cfg_skew;
              word_cnt <= '0;
              rep_cnt  <= '0;
              tail_cnt <= '0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= IDLE;
          end else if (!stall) begin
            if (last_word) begin
              state <= use_tail ? TAIL : IDLE;
            end else if (word_wrap) begin
              word_cnt <= '0;
              rep_cnt  <= rep_cnt + REP_WIDTH'(1);
            end else begin
              word_cnt <= word_cnt + LEN_WIDTH'(1);
            end
          end
        end
        TAIL: begin
          if (abort) begin
            state <= IDLE;
          end else if (!stall) begin
            if (tail_last) begin
              state <= IDLE;
            end else begin
              tail_cnt <= tail_cnt + TAIL_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  lane_skew_shreg #(
    .WIDTH (FIFO_WIDTH)
  ) u_lane_skew (
    .clk  (clk),
    .rstn (rstn),
    .hold (sr_hold),
    .clr  (sr_clr),
    .skew (sr_skew),
    .din  (sr_din),
    .q    (lane_act)
  );

  assign busy    = (state != IDLE);
  assign done    = done_c;
  assign fifo_en = lane_act & {FIFO_WIDTH{!stall}};
  assign w_wen   = lane_act & {FIFO_WIDTH{!stall}};

endmodule

// File: tb/tb_weight_fifo_drain_ctrl.sv
// Bench for weight_fifo_drain_ctrl: vector table, directed corner cases and
// random traffic checked against a progress-count reference model.
module tb_weight_fifo_drain_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned D  = 8;
  localparam int unsigned RW = 8;
  localparam int unsigned LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [LW-1:0] cfg_len;
  logic [RW-1:0] cfg_repeat;
  logic          cfg_skew;
  logic          stall;
  logic          abort;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic [W-1:0]  fifo_en;
  logic [W-1:0]  w_wen;

  always #5 clk = ~clk;

  weight_fifo_drain_ctrl #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (D),
    .REP_WIDTH  (RW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .cfg_len    (cfg_len),
    .cfg_repeat (cfg_repeat),
    .cfg_skew   (cfg_skew),
    .stall      (stall),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .fifo_en    (fifo_en),
    .w_wen      (w_wen)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a launch is N words per lane; p counts un-stalled busy
  // cycles already completed; lane i fires on progress index p when
  // 0 <= p - (skew ? i : 0) < N; the launch ends after N + skew*(W-1) of them.
  bit m_busy = 1'b0;
  bit m_skew = 1'b0;
  bit m_err  = 1'b0;
  int m_n = 0;
  int m_t = 0;
  int m_p = 0;

  logic         o_busy;
  logic         o_done;
  logic         o_err;
  logic [W-1:0] o_en;
  int           lane_cnt [W];
  int           done_cnt;
  int           done_at;
  int           cyc_idx;

  typedef struct {
    logic         st;
    int           ln;
    int           rp;
    logic         sk;
    logic         sl;
    logic         ab;
    logic         e_busy;
    logic         e_done;
    logic         e_err;
    logic [W-1:0] e_en;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < W; i++) lane_cnt[i] = 0;
    done_cnt = 0;
    done_at  = -1;
    cyc_idx  = 0;
  endtask

  // One clock: drive after the edge, check at negedge, advance model at posedge.
  task automatic cyc(input logic st, input int ln, input int rp,
                     input logic sk, input logic sl, input logic ab);
    logic [W-1:0] e_en;
    logic         e_done;
    int           lv;
    int           idx;
    bit           n_err;
    start      = st;
    cfg_len    = LW'(ln);
    cfg_repeat = RW'(rp);
    cfg_skew   = sk;
    stall      = sl;
    abort      = ab;
    @(negedge clk);
    e_en = '0;
    for (int i = 0; i < W; i++) begin
      idx = m_p - (m_skew ? i : 0);
      if (m_busy && !sl && idx >= 0 && idx < m_n) e_en[i] = 1'b1;
    end
    e_done = m_busy && !sl && !ab && (m_p == m_t - 1);
    o_busy = busy;
    o_done = done;
    o_err  = cfg_err;
    o_en   = fifo_en;
    chk("busy",    32'(o_busy), 32'(m_busy));
    chk("done",    32'(o_done), 32'(e_done));
    chk("cfg_err", 32'(o_err),  32'(m_err));
    chk("fifo_en", 32'(o_en),   32'(e_en));
    chk("w_wen",   32'(w_wen),  32'(e_en));
    for (int i = 0; i < W; i++) lane_cnt[i] += int'(o_en[i]);
    if (o_done) begin
      done_cnt++;
      done_at = cyc_idx;
    end
    cyc_idx++;
    @(posedge clk);
    lv    = int'(cfg_len);
    n_err = !m_busy && st && !ab && (lv == 0);
    if (m_busy) begin
      if (ab) begin
        m_busy = 1'b0;
      end else if (!sl) begin
        m_p++;
        if (m_p == m_t) m_busy = 1'b0;
      end
    end else if (st && !ab && lv != 0) begin
      m_busy = 1'b1;
      m_skew = sk;
      m_n    = ((lv > D) ? D : lv) * ((rp == 0) ? 1 : rp);
      m_t    = m_n + (sk ? W - 1 : 0);
      m_p    = 0;
    end
    m_err = n_err;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Launch and run until busy drops, bounded.
  task automatic run_launch(input int ln, input int rp, input logic sk);
    int n;
    clear_stats();
    cyc(1'b1, ln, rp, sk, 1'b0, 1'b0);
    n = 0;
    do begin
      idle();
      n++;
    end while (o_busy && n < 60);
    chk("launch_timeout", 32'(o_busy), 32'd0);
  endtask

  function automatic void add(input logic st, input int ln, input int rp, input logic sk,
                              input logic b, input logic dn, input logic er, input logic [W-1:0] en);
    vec_t v;
    v.st = st; v.ln = ln; v.rp = rp; v.sk = sk; v.sl = 1'b0; v.ab = 1'b0;
    v.e_busy = b; v.e_done = dn; v.e_err = er; v.e_en = en;
    tbl.push_back(v);
  endfunction

  initial begin
    // Aligned burst, len=8 rep=1.
    add(1, 8, 1, 0, 0, 0, 0, 4'h0);
    for (int k = 0; k < 7; k++) add(0, 0, 0, 0, 1, 0, 0, 4'hF);
    add(0, 0, 0, 0, 1, 1, 0, 4'hF);
    // Zero-length start rejected.
    add(1, 0, 1, 0, 0, 0, 0, 4'h0);
    add(0, 0, 0, 0, 0, 0, 1, 4'h0);
    // Skewed len=3 rep=2, with a start while busy that must be ignored.
    add(1, 3, 2, 1, 0, 0, 0, 4'h0);
    add(0, 0, 0, 0, 1, 0, 0, 4'b0001);
    add(0, 0, 0, 0, 1, 0, 0, 4'b0011);
    add(1, 5, 1, 0, 1, 0, 0, 4'b0111);
    add(0, 0, 0, 0, 1, 0, 0, 4'b1111);
    add(0, 0, 0, 0, 1, 0, 0, 4'b1111);
    add(0, 0, 0, 0, 1, 0, 0, 4'b1111);
    add(0, 0, 0, 0, 1, 0, 0, 4'b1110);
    add(0, 0, 0, 0, 1, 0, 0, 4'b1100);
    add(0, 0, 0, 0, 1, 1, 0, 4'b1000);
    add(0, 0, 0, 0, 0, 0, 0, 4'b0000);

    rstn = 1'b0; start = 1'b0; cfg_len = '0; cfg_repeat = '0;
    cfg_skew = 1'b0; stall = 1'b0; abort = 1'b0;
    clear_stats();
    #12;
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_fifo_en", 32'(fifo_en), 32'd0);
    chk("rst_w_wen",   32'(w_wen),   32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < tbl.size(); k++) begin
      cyc(tbl[k].st, tbl[k].ln, tbl[k].rp, tbl[k].sk, tbl[k].sl, tbl[k].ab);
      chk($sformatf("tbl%0d_busy", k),    32'(o_busy), 32'(tbl[k].e_busy));
      chk($sformatf("tbl%0d_done", k),    32'(o_done), 32'(tbl[k].e_done));
      chk($sformatf("tbl%0d_cfg_err", k), 32'(o_err),  32'(tbl[k].e_err));
      chk($sformatf("tbl%0d_fifo_en", k), 32'(o_en),   32'(tbl[k].e_en));
    end

    // Two-cycle stall in the middle of a skewed len=4 burst.
    clear_stats();
    cyc(1'b1, 4, 1, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c < 12; c++) cyc(1'b0, 0, 0, 1'b0, (c == 3 || c == 4), 1'b0);
    chk("stall_done_cycle", 32'(done_at), 32'd9);
    chk("stall_done_count", 32'(done_cnt), 32'd1);
    for (int i = 0; i < W; i++) chk($sformatf("stall_lane%0d_words", i), 32'(lane_cnt[i]), 32'd4);

    // Length clamp and zero repeat.
    run_launch(12, 1, 1'b0);
    for (int i = 0; i < W; i++) chk($sformatf("clamp_lane%0d_words", i), 32'(lane_cnt[i]), 32'd8);
    run_launch(3, 0, 1'b1);
    for (int i = 0; i < W; i++) chk($sformatf("rep0_lane%0d_words", i), 32'(lane_cnt[i]), 32'd3);
    chk("rep0_done_count", 32'(done_cnt), 32'd1);

    // Abort at cycle 2, restart the cycle after.
    clear_stats();
    cyc(1'b1, 8, 1, 1'b0, 1'b0, 1'b0);
    idle();
    cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 2, 1, 1'b0, 1'b0, 1'b0);
    chk("abort_busy_low", 32'(o_busy), 32'd0);
    chk("abort_en_zero",  32'(o_en),   32'd0);
    chk("abort_no_done",  32'(done_cnt), 32'd0);
    idle();
    chk("restart_busy", 32'(o_busy), 32'd1);
    idle();
    idle();
    chk("restart_done_count", 32'(done_cnt), 32'd1);

    // Abort coinciding with the final word suppresses done.
    clear_stats();
    cyc(1'b1, 1, 1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("abort_final_no_done", 32'(done_cnt), 32'd0);

    // Stall on the final word holds done back one cycle.
    clear_stats();
    cyc(1'b1, 2, 1, 1'b0, 1'b0, 1'b0);
    idle();
    cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    idle();
    idle();
    chk("stall_final_done_cycle", 32'(done_at), 32'd3);

    // Asynchronous reset in the middle of the skew tail.
    clear_stats();
    cyc(1'b1, 2, 1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 5, 1, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    chk("pre_rst_lane0_words", 32'(lane_cnt[0]), 32'd2);
    start = 1'b0;
    #2;
    chk("pre_rst_fifo_en", 32'(fifo_en), 32'b1100);
    rstn = 1'b0;
    #1;
    chk("async_rst_fifo_en", 32'(fifo_en), 32'd0);
    chk("async_rst_w_wen",   32'(w_wen),   32'd0);
    chk("async_rst_busy",    32'(busy),    32'd0);
    chk("async_rst_done",    32'(done),    32'd0);
    m_busy = 1'b0;
    m_err  = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    idle();
    chk("post_rst_idle", 32'(o_busy), 32'd0);
    chk("post_rst_no_done", 32'(done_cnt), 32'd0);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom % 4) == 0, int'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
          1'($urandom % 2), ($urandom % 4) == 0, ($urandom % 40) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
